sde_ps_rd_pack: RTL and testbench
=================================

# sde_ps_rd_pack

Read-direction companion to the PCIS write accumulator in the SDE streaming path. On a read request from the PS FSM it fetches ACC_WIDTH-bit words from a slave with a req/ack handshake, packs them LSB-first into PCIS_DATA_WIDTH-bit beats, and returns those beats on the PCIS read-data channel with AXI-style valid/ready/last. Double buffering (fill buffer plus output register) sustains one word per cycle under light PCIS backpressure.

## Interface
Parameters:
- PCIS_DATA_WIDTH, 512, PCIS read beat width; integer multiple of ACC_WIDTH.
- PCIS_ADDR_WIDTH, 64, request address width.
- PCIS_LEN_WIDTH, 8, burst length field width; the field encodes beats-1.
- ACC_WIDTH, 64, slave word width.
- START_ADDR, 64'd0, address exempt from the out-of-order check.
- Derived: WPB = PCIS_DATA_WIDTH/ACC_WIDTH words per beat; must be a power of two, ≥1.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset; synchronous, active-low.
- rd_req_valid, in, 1, PS FSM read request.
- rd_req_addr, in, PCIS_ADDR_WIDTH, request address.
- rd_req_len, in, PCIS_LEN_WIDTH, beats-1.
- rd_req_ready, out, 1, request accepted when valid & ready.
- acc_rd_req, out, 1, word fetch request to slave.
- acc_rdata, in, ACC_WIDTH, slave word; valid when acc_rd_req & acc_rd_ack.
- acc_rd_ack, in, 1, slave word acknowledge.
- pcis_rdata, out, PCIS_DATA_WIDTH, read beat.
- pcis_rlast, out, 1, final beat of burst.
- pcis_rvalid, out, 1, beat valid.
- pcis_rready, in, 1, beat accepted.
- ooo_error, out, 1, out-of-order address pulse.
- unalin_error, out, 1, unaligned address pulse.

## Operation
- States: IDLE, FETCH, DRAIN.
  - rd_req_ready = (state==IDLE) & rst_n.
  - Request accept in IDLE: latch len; words_left = (len+1)*WPB (counter width PCIS_LEN_WIDTH+log2(WPB)+1); beats_left = len+1; go to FETCH.
- FETCH:
  - acc_rd_req = (words_left != 0) & ~fill_full.
  - Each req & ack writes acc_rdata into fill[fill_cnt*ACC_WIDTH +: ACC_WIDTH] and increments fill_cnt. It also decrements words_left.
  - The WPB-th word completes the beat and fill_cnt wraps to 0.
    - If the output slot is free that cycle (~pcis_rvalid | pcis_rready), the completed beat, including the word just acked, loads straight into the output register.
    - Otherwise fill_full is set.
  - While fill_full is set, the fill buffer transfers to the output register in any cycle the output slot is free, and fill_full clears.
  - When words_left reaches 0, go to DRAIN.
- DRAIN: hold until the beat with beats_left==1 handshakes, then go to IDLE. rd_req_ready rises in the following cycle.
- pcis_rlast = 1 exactly on the beat loaded while beats_left==1. beats_left decrements on each pcis_rvalid & pcis_rready.
- While pcis_rvalid & ~pcis_rready, pcis_rdata and pcis_rlast must not change.
- Address checks on every accepted request; both are one-cycle pulses the next cycle and never assert in consecutive cycles:
  - unalin_error when addr[5:0] != 0. The low bits are otherwise ignored and data is returned as aligned.
  - ooo_error when addr < previous accepted addr and addr != START_ADDR. The previous-address register resets to 0.
  - Neither error blocks the transfer.

## Timing
- Reset values: rd_req_ready 0, acc_rd_req 0, pcis_rvalid 0, pcis_rlast 0, pcis_rdata 0, both errors 0.
  - Reset mid-burst discards all buffered and in-flight data.
  - First post-reset cycle: IDLE, rd_req_ready 1.
- Request accepted in cycle T: acc_rd_req is first high in T+1.
- With ack every cycle and rready high, beat 0 words arrive T+1..T+WPB and pcis_rvalid rises in T+WPB+1.
- Sustained rate is one word per cycle. A fill_full stall costs one bubble cycle on acc_rd_req after the transfer.
- Slave may hold acc_rd_ack high continuously; a word is consumed only when acc_rd_req is also high.

## Test plan
- Single beat: len=0, addr 0x1000, ack every cycle, words 1..8 (WPB=8) -> pcis_rdata={8,7,…,1} in T+9 with rvalid=1, rlast=1; rd_req_ready returns high the cycle after the handshake.
- Backpressure: len=3, rready=0 until cycle 40 -> acc_rd_req drops after 16 words (output plus fill full). Then 4 beats in order, rlast only on the 4th, rdata stable while stalled.
- Ack gaps: len=1, ack on alternate cycles -> 16 words, 2 beats, same packing, total ≥32 cycles, no lost or duplicated word.
- Errors: request 0x2000, then 0x1000 -> ooo_error one-cycle pulse. Then START_ADDR 0x0 -> no ooo_error. Then 0x3004 -> unalin_error pulse; data still returned.
- Reset mid-burst: rst_n low during beat 1 of len=3 -> next cycle all outputs at reset values. A new len=0 request afterward returns only new words.

Source files
------------

// File: rtl/sde_ps_rd_pack.sv
// PCIS read-direction packer: fetches ACC_WIDTH words from the accumulator slave and
// returns them LSB-first as PCIS_DATA_WIDTH beats on an AXI-style valid/ready/last channel.
//
//   state | meaning
//   IDLE  | waiting for a read request from the PS FSM
//   FETCH | requesting words from the slave and packing beats
//   DRAIN | all words fetched; waiting for the last beat to handshake
module sde_ps_rd_pack #(
    parameter int PCIS_DATA_WIDTH = 512,
    parameter int PCIS_ADDR_WIDTH = 64,
    parameter int PCIS_LEN_WIDTH  = 8,
    parameter int ACC_WIDTH       = 64,
    parameter logic [PCIS_ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_req_valid,
    input  logic [PCIS_ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [PCIS_LEN_WIDTH-1:0]  rd_req_len,
    output logic                       rd_req_ready,
    output logic                       acc_rd_req,
    input  logic [ACC_WIDTH-1:0]       acc_rdata,
    input  logic                       acc_rd_ack,
    output logic [PCIS_DATA_WIDTH-1:0] pcis_rdata,
    output logic                       pcis_rlast,
    output logic                       pcis_rvalid,
    input  logic                       pcis_rready,
    output logic                       ooo_error,
    output logic                       unalin_error
);
    localparam int WPB  = PCIS_DATA_WIDTH / ACC_WIDTH;
    localparam int LWPB = $clog2(WPB);
    localparam int CW   = (WPB > 1) ? LWPB : 1;
    localparam int WLW  = PCIS_LEN_WIDTH + LWPB + 1;
    localparam int BLW  = PCIS_LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [WLW-1:0]             words_left_q, words_left_d;
    logic [BLW-1:0]             beats_left_q, beats_left_d;
    logic [PCIS_DATA_WIDTH-1:0] fill_q, fill_d, fill_ins;
    logic [CW-1:0]              fill_cnt_q, fill_cnt_d;
    logic                       fill_full_q, fill_full_d;
    logic [PCIS_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                       rlast_q, rlast_d;
    logic                       rvalid_q, rvalid_d;
    logic [PCIS_ADDR_WIDTH-1:0] prev_addr_q, prev_addr_d;
    logic                       ooo_q, ooo_d;
    logic                       unalin_q, unalin_d;

    logic req_acc, word_fire, beat_done, slot_free, rd_hs, last_load;

    assign rd_req_ready = (state_q == IDLE) & rst_n;
    assign acc_rd_req   = rst_n & (state_q == FETCH) & (words_left_q != '0) & ~fill_full_q;
    assign pcis_rdata   = rdata_q;
    assign pcis_rlast   = rlast_q;
    assign pcis_rvalid  = rvalid_q;
    assign ooo_error    = ooo_q;
    assign unalin_error = unalin_q;

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        beats_left_d = beats_left_q;
        fill_d       = fill_q;
        fill_cnt_d   = fill_cnt_q;
        fill_full_d  = fill_full_q;
        rdata_d      = rdata_q;
        rlast_d      = rlast_q;
        rvalid_d     = rvalid_q;
        prev_addr_d  = prev_addr_q;
        ooo_d        = 1'b0;
        unalin_d     = 1'b0;

        req_acc   = rd_req_valid & rd_req_ready;
        word_fire = acc_rd_req & acc_rd_ack;
        beat_done = word_fire & (fill_cnt_q == CW'(WPB - 1));
        slot_free = ~rvalid_q | pcis_rready;
        rd_hs     = rvalid_q & pcis_rready;
        // A beat loaded in the same cycle its predecessor handshakes sees beats_left one high.
        last_load = (beats_left_q == (rd_hs ? BLW'(2) : BLW'(1)));

        fill_ins = fill_q;
        fill_ins[fill_cnt_q*ACC_WIDTH +: ACC_WIDTH] = acc_rdata;

        if (rd_hs) begin
            rvalid_d     = 1'b0;
            rlast_d      = 1'b0;
            beats_left_d = beats_left_q - BLW'(1);
        end

        if (word_fire) begin
            fill_d       = fill_ins;
            fill_cnt_d   = beat_done ? '0 : fill_cnt_q + CW'(1);
            words_left_d = words_left_q - WLW'(1);
        end

        if (fill_full_q && slot_free) begin
            rdata_d     = fill_q;
            rlast_d     = last_load;
            rvalid_d    = 1'b1;
            fill_full_d = 1'b0;
        end else if (beat_done) begin
            if (slot_free) begin
                rdata_d  = fill_ins;
                rlast_d  = last_load;
                rvalid_d = 1'b1;
            end else begin
                fill_full_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (req_acc) begin
                    words_left_d = (WLW'(rd_req_len) + WLW'(1)) << LWPB;
                    beats_left_d = BLW'(rd_req_len) + BLW'(1);
                    fill_cnt_d   = '0;
                    unalin_d     = (rd_req_addr[5:0] != 6'd0);
                    ooo_d        = (rd_req_addr < prev_addr_q) && (rd_req_addr != START_ADDR);
                    prev_addr_d  = rd_req_addr;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (word_fire && (words_left_q == WLW'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_hs && (beats_left_q == BLW'(1))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            beats_left_q <= '0;
            fill_q       <= '0;
            fill_cnt_q   <= '0;
            fill_full_q  <= 1'b0;
            rdata_q      <= '0;
            rlast_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            prev_addr_q  <= '0;
            ooo_q        <= 1'b0;
            unalin_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            beats_left_q <= beats_left_d;
            fill_q       <= fill_d;
            fill_cnt_q   <= fill_cnt_d;
            fill_full_q  <= fill_full_d;
            rdata_q      <= rdata_d;
            rlast_q      <= rlast_d;
            rvalid_q     <= rvalid_d;
            prev_addr_q  <= prev_addr_d;
            ooo_q        <= ooo_d;
            unalin_q     <= unalin_d;
        end
    end
endmodule

// File: tb/tb_sde_ps_rd_pack.sv
// Bench for sde_ps_rd_pack: directed scenarios plus randomized traffic, checked against a
// word-queue model of the burst (WPB words per beat, LSB-first, last on final beat).
module tb_sde_ps_rd_pack;
    localparam int WPB = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_req_valid = 1'b0;
    logic [63:0]  rd_req_addr = '0;
    logic [7:0]   rd_req_len = '0;
    logic         rd_req_ready;
    logic         acc_rd_req;
    logic [63:0]  acc_rdata = '0;
    logic         acc_rd_ack = 1'b0;
    logic [511:0] pcis_rdata;
    logic         pcis_rlast;
    logic         pcis_rvalid;
    logic         pcis_rready = 1'b0;
    logic         ooo_error;
    logic         unalin_error;

    sde_ps_rd_pack dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_req_ready(rd_req_ready),
        .acc_rd_req(acc_rd_req), .acc_rdata(acc_rdata), .acc_rd_ack(acc_rd_ack),
        .pcis_rdata(pcis_rdata), .pcis_rlast(pcis_rlast), .pcis_rvalid(pcis_rvalid),
        .pcis_rready(pcis_rready),
        .ooo_error(ooo_error), .unalin_error(unalin_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus controls
    int          ack_mode = 0;   // 0 always, 1 alternate, 2 random, 3 never
    int          rr_mode  = 1;   // 0 low, 1 high, 2 random
    logic [63:0] seq_val  = 64'd1;
    bit          g_req = 0;
    logic [63:0] g_addr = '0;
    logic [7:0]  g_len = '0;

    // reference model
    logic [63:0]  wq[$];
    int           words_need = 0;
    int           beats_rem  = 0;
    bit           idle_exp   = 1;
    bit           exp_ooo = 0, exp_unal = 0;
    logic [63:0]  prev_addr_m = '0;
    bit           stalled = 0;
    logic [511:0] st_data;
    logic         st_last;
    int cyc = 0, words_fired = 0, beats_seen = 0, ooo_seen = 0, unal_seen = 0;
    int accept_cyc = 0, first_req_cyc = -1, first_valid_cyc = -1, last_hs_cyc = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [511:0] eb;
        bit acc_now, nxt_ooo, nxt_unal;
        @(negedge clk);
        cyc++;
        rd_req_valid = g_req;
        rd_req_addr  = g_addr;
        rd_req_len   = g_len;
        case (ack_mode)
            0: acc_rd_ack = 1'b1;
            1: acc_rd_ack = cyc[0];
            2: acc_rd_ack = ($urandom_range(3) != 0);
            default: acc_rd_ack = 1'b0;
        endcase
        acc_rdata = seq_val;
        case (rr_mode)
            0: pcis_rready = 1'b0;
            1: pcis_rready = 1'b1;
            default: pcis_rready = ($urandom_range(3) != 0);
        endcase
        #1;
        chk("rd_req_ready", rd_req_ready, idle_exp);
        chk("ooo_error", ooo_error, exp_ooo);
        chk("unalin_error", unalin_error, exp_unal);
        if (stalled) begin
            chk("rdata_stable", pcis_rdata, st_data);
            chk("rlast_stable", pcis_rlast, st_last);
        end
        if (words_need == 0) chk("acc_rd_req_none", acc_rd_req, 1'b0);
        if (beats_rem == 0) chk("rvalid_none", pcis_rvalid, 1'b0);
        if (ooo_error) ooo_seen++;
        if (unalin_error) unal_seen++;
        if (acc_rd_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (pcis_rvalid && first_valid_cyc < 0) first_valid_cyc = cyc;

        acc_now  = rd_req_valid && rd_req_ready;
        nxt_ooo  = 0;
        nxt_unal = 0;
        if (pcis_rvalid && pcis_rready) begin
            if (wq.size() < WPB) begin
                chk("beat_words", wq.size(), WPB);
                wq.delete();
            end else begin
                for (int i = 0; i < WPB; i++) eb[i*64 +: 64] = wq.pop_front();
                chk("rdata", pcis_rdata, eb);
            end
            chk("rlast", pcis_rlast, (beats_rem == 1));
            beats_seen++;
            if (beats_rem == 1) begin
                idle_exp    = 1;
                last_hs_cyc = cyc;
            end
            beats_rem--;
        end
        if (acc_rd_req && acc_rd_ack) begin
            wq.push_back(acc_rdata);
            words_need--;
            words_fired++;
            seq_val = seq_val + 64'd1;
        end
        if (acc_now) begin
            g_req       = 0;
            words_need  = (int'(rd_req_len) + 1) * WPB;
            beats_rem   = int'(rd_req_len) + 1;
            nxt_unal    = (rd_req_addr % 64) != 0;
            nxt_ooo     = (rd_req_addr < prev_addr_m) && (rd_req_addr != 64'd0);
            prev_addr_m = rd_req_addr;
            idle_exp    = 0;
            accept_cyc  = cyc;
        end
        exp_ooo  = nxt_ooo;
        exp_unal = nxt_unal;
        stalled  = pcis_rvalid && !pcis_rready;
        st_data  = pcis_rdata;
        st_last  = pcis_rlast;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rd_req_valid = 1'b0; acc_rd_ack = 1'b0; pcis_rready = 1'b0; g_req = 0;
        #1;
        chk("rst_ready_comb", rd_req_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_rd_req_ready", rd_req_ready, 1'b0);
        chk("rst_acc_rd_req", acc_rd_req, 1'b0);
        chk("rst_rvalid", pcis_rvalid, 1'b0);
        chk("rst_rlast", pcis_rlast, 1'b0);
        chk("rst_rdata", pcis_rdata, '0);
        chk("rst_ooo", ooo_error, 1'b0);
        chk("rst_unalin", unalin_error, 1'b0);
        wq.delete();
        words_need = 0; beats_rem = 0; idle_exp = 1;
        exp_ooo = 0; exp_unal = 0; prev_addr_m = '0; stalled = 0;
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [63:0] addr, input logic [7:0] len);
        g_addr = addr; g_len = len; g_req = 1;
        words_fired = 0; beats_seen = 0; first_req_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((g_req || !idle_exp || beats_rem != 0) && n < max) begin
            step();
            n++;
        end
        chk("wait_within_budget", (n < max), 1'b1);
        step();
        chk("end_words_left", words_need, 0);
        chk("end_queue_empty", wq.size(), 0);
    endtask

    initial begin
        do_reset();
        step();

        // single beat, words 1..8
        ack_mode = 0; rr_mode = 1; seq_val = 64'd1;
        issue(64'h1000, 8'd0);
        run_until_idle(200);
        chk("single_req_latency", first_req_cyc - accept_cyc, 1);
        chk("single_rvalid_latency", first_valid_cyc - accept_cyc, WPB + 1);
        chk("single_beats", beats_seen, 1);

        // backpressure: output register plus fill buffer hold 16 words
        rr_mode = 0;
        issue(64'h1100, 8'd3);
        for (int i = 0; i < 40; i++) step();
        chk("bp_words_before_stall", words_fired, 2 * WPB);
        chk("bp_acc_rd_req_low", acc_rd_req, 1'b0);
        rr_mode = 1;
        run_until_idle(400);
        chk("bp_beats", beats_seen, 4);
        chk("bp_words", words_fired, 4 * WPB);

        // alternate-cycle acks
        ack_mode = 1;
        issue(64'h1200, 8'd1);
        run_until_idle(400);
        chk("gap_words", words_fired, 2 * WPB);
        chk("gap_beats", beats_seen, 2);
        chk("gap_duration_ge32", ((last_hs_cyc - accept_cyc) >= 32), 1'b1);
        ack_mode = 0;

        // address checks
        ooo_seen = 0; unal_seen = 0;
        issue(64'h2000, 8'd0); run_until_idle(200);
        issue(64'h1000, 8'd0); run_until_idle(200);
        chk("ooo_pulses_after_backstep", ooo_seen, 1);
        issue(64'h0, 8'd0); run_until_idle(200);
        chk("ooo_pulses_start_addr", ooo_seen, 1);
        issue(64'h3004, 8'd0); run_until_idle(200);
        chk("unalin_pulses", unal_seen, 1);
        chk("unalin_data_beats", beats_seen, 1);

        // reset during beat 1 of a 4-beat burst
        begin
            int n = 0;
            issue(64'h4000, 8'd3);
            while (beats_seen < 1 && n < 200) begin step(); n++; end
            chk("pre_reset_beat0", beats_seen, 1);
        end
        do_reset();
        seq_val = 64'h100;
        issue(64'h5000, 8'd0);
        run_until_idle(200);
        chk("post_reset_beats", beats_seen, 1);
        chk("post_reset_words", words_fired, WPB);

        // randomized traffic
        ack_mode = 2; rr_mode = 2;
        for (int r = 0; r < 25; r++) begin
            logic [63:0] a;
            a = {32'h0, $urandom};
            if ($urandom_range(1) == 0) a[5:0] = 6'd0;
            issue(a, 8'($urandom_range(3)));
            run_until_idle(1000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
